// File: rtl/apu_dac_serializer_if.sv
// Mix-bus input and DAC pin bundle for apu_dac_serializer.
// The slave modport is the serializer's view; the master modport is the APU/board view.
interface apu_dac_serializer_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] sample_i;
    logic                mute_i;
    logic                sysck_o;
    logic                bck_o;
    logic                lrclk_o;
    logic                data_o;
    logic                mute_o;
    logic                fmt_o;
    logic                emp_o;
    logic                frame_o;

    modport slave (
        input  sample_i, mute_i,
        output sysck_o, bck_o, lrclk_o, data_o, mute_o, fmt_o, emp_o, frame_o
    );

    modport master (
        output sample_i, mute_i,
        input  sysck_o, bck_o, lrclk_o, data_o, mute_o, fmt_o, emp_o, frame_o
    );
endinterface

// File: rtl/apu_dac_serializer.sv
// Box-filter decimator (x128) and left-justified serializer for the external audio DAC.
// Optional feature macro APU_DAC_DITHER_EN adds LFSR dither ahead of the word truncation.
module apu_dac_serializer #(
    parameter int SAMPLE_W   = 16,
    parameter int DECIM_LOG2 = 7
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    apu_dac_serializer_if.slave  bus
);
    localparam int DIV_W = DECIM_LOG2 + 1;
    localparam int ACC_W = SAMPLE_W + DECIM_LOG2;

    logic [DIV_W-1:0]    div_q,   div_d;
    logic [ACC_W-1:0]    acc_q,   acc_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                mute_q,  mute_d;
    logic                frame_q, frame_d;

    logic                load_s;
    logic                bck_fall_s;
    logic [ACC_W-1:0]    sum_s;
    logic [ACC_W-1:0]    round_s;
    logic [SAMPLE_W-1:0] word_s;

`ifdef APU_DAC_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR step, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
`endif

    // Slot timing decode and the decimated word for this edge
    always_comb begin
        load_s     = (div_q[DECIM_LOG2-1:0] == {DECIM_LOG2{1'b1}});
        bck_fall_s = (div_q[1:0] == 2'b11);
        sum_s      = acc_q + {{DECIM_LOG2{1'b0}}, bus.sample_i};
`ifdef APU_DAC_DITHER_EN
        round_s    = sum_s + {{(ACC_W-DECIM_LOG2){1'b0}}, lfsr_q[DECIM_LOG2-1:0]};
`else
        round_s    = sum_s;
`endif
        // mute uses the value registered before the load edge
        if (mute_q) begin
            word_s = {SAMPLE_W{1'b0}};
        end else begin
            word_s = round_s[ACC_W-1:DECIM_LOG2];
        end
    end

    // Next-state for divider, accumulator, shifter and strobes
    always_comb begin
        div_d  = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        mute_d = bus.mute_i;
        if (load_s) begin
            acc_d   = {ACC_W{1'b0}};
            shift_d = word_s;
            frame_d = 1'b1;
        end else begin
            acc_d   = sum_s;
            frame_d = 1'b0;
            if (bck_fall_s) begin
                shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
            end else begin
                shift_d = shift_q;
            end
        end
    end

`ifdef APU_DAC_DITHER_EN
    // Dither sequence advances once per loaded word
    always_comb begin
        if (load_s) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Dither state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // State registers; reset discards any partial accumulation
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q   <= {DIV_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            shift_q <= {SAMPLE_W{1'b0}};
            mute_q  <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            mute_q  <= mute_d;
            frame_q <= frame_d;
        end
    end

    assign bus.sysck_o = div_q[0];
    assign bus.bck_o   = div_q[1];
    assign bus.lrclk_o = div_q[DIV_W-1];
    assign bus.data_o  = shift_q[SAMPLE_W-1];
    assign bus.mute_o  = mute_q;
    assign bus.frame_o = frame_q;
    assign bus.fmt_o   = 1'b1;
    assign bus.emp_o   = 1'b1;
endmodule

// File: tb/tb_apu_dac_serializer.sv
// Scoreboard bench for apu_dac_serializer: a slot-sum reference model queues expected
// words, and a separate monitor rebuilds words from data_o after each frame strobe.
module tb_apu_dac_serializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apu_dac_serializer_if #(.SAMPLE_W(16)) bus ();

    apu_dac_serializer #(.SAMPLE_W(16), .DECIM_LOG2(7)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int words_seen = 0;
    logic [15:0] exp_q[$];

    // model state: edges since reset, running slot sum, last registered mute
    int     ncyc = 0;
    longint slot_sum = 0;
    bit     mute_reg = 1'b1;
    bit     started = 1'b0;
    logic [15:0] lfsr = 16'hACE1;

    task automatic report(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Check pins against the model, then apply inputs for the next edge and advance the model
    task automatic step(input logic [15:0] s, input bit m, input bit r);
        int d;
        logic [6:0] pins_e;
        logic [6:0] pins_a;
        logic [15:0] w;
        if (started) begin
            d = ncyc % 256;
            pins_e = {1'(d % 2), 1'((d / 2) % 2), 1'(d / 128),
                      1'(ncyc > 0 && ncyc % 128 == 0), mute_reg, 1'b1, 1'b1};
            pins_a = {bus.sysck_o, bus.bck_o, bus.lrclk_o, bus.frame_o,
                      bus.mute_o, bus.fmt_o, bus.emp_o};
            report("pins", 32'(pins_a), 32'(pins_e));
            if (ncyc < 128) report("first_slot_data", 32'(bus.data_o), 32'd0);
        end
        bus.sample_i = s;
        bus.mute_i   = m;
        reset        = r;
        if (r) begin
            ncyc = 0;
            slot_sum = 0;
            mute_reg = 1'b1;
            lfsr = 16'hACE1;
            exp_q.delete();
            started = 1'b1;
        end else begin
            slot_sum += longint'(s);
            if (ncyc % 128 == 127) begin
`ifdef APU_DAC_DITHER_EN
                w = 16'((slot_sum + longint'(lfsr % 128)) / 128);
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`else
                w = 16'(slot_sum / 128);
`endif
                exp_q.push_back(mute_reg ? 16'h0000 : w);
                slot_sum = 0;
            end
            mute_reg = m;
            ncyc++;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Monitor: after each frame strobe, capture 16 data bits mid-BCK-high, then 16 tail bits
    int mt = 0;
    bit mactive = 1'b0;
    logic [15:0] mbits;
    logic mtail;
    always @(negedge clk) begin
        if (reset) begin
            mactive = 1'b0;
        end else if (bus.frame_o) begin
            mactive = 1'b1;
            mt = 0;
            mbits = 16'h0000;
            mtail = 1'b0;
        end else if (mactive) begin
            mt++;
        end
        if (mactive && !reset && (mt % 4 == 2)) begin
            if (mt < 64) begin
                mbits[15 - mt / 4] = bus.data_o;
                if (mt == 62) begin
                    report("word_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        report("word", 32'(mbits), 32'(exp_q.pop_front()));
                        words_seen++;
                    end
                end
            end else begin
                mtail = mtail | bus.data_o;
                if (mt == 126) begin
                    report("tail_zero", 32'(mtail), 32'd0);
                    mactive = 1'b0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.sample_i = 16'h0000;
        bus.mute_i = 1'b0;
        @(negedge clk);
        #1;
        repeat (10) step(16'h0000, 1'b0, 1'b1);
        repeat (512) step(16'h1234, 1'b0, 1'b0);
        repeat (512) step(16'hFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 512; i++) step((i % 2 == 1) ? 16'h0100 : 16'h0000, 1'b0, 1'b0);
        repeat (256) step(16'($urandom), 1'b1, 1'b0);
        begin
            bit m = 1'b0;
            for (int i = 0; i < 1024; i++) begin
                if ($urandom_range(0, 15) == 0) m = ~m;
                step(16'($urandom), m, 1'b0);
            end
        end
        for (int i = 0; i < 256 && (ncyc % 256) != 70; i++) step(16'($urandom) | 16'h8000, 1'b0, 1'b0);
        repeat (3) step(16'($urandom), 1'b0, 1'b1);
        repeat (640) step(16'($urandom), 1'b0, 1'b0);
        repeat (200) step(16'h0000, 1'b0, 1'b0);
        report("words_checked_min", 32'(words_seen >= 20), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
